// File: rtl/gray_conv_arbiter.sv
// rtl/gray_conv_arbiter.sv - round-robin shared binary/Gray converter with one registered output slot
//
// Ports:
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   req_data_i   packed request words, requester i at [i*D_WIDTH +: D_WIDTH]
//   req_mode_i   per-requester mode, 0 = bin2gray, 1 = gray2bin
//   req_valid_i  per-requester request valid
//   req_ready_o  per-requester accept, at most one bit high
//   out_data_o   converted word
//   out_mode_o   mode used for out_data_o
//   out_id_o     requester index that produced out_data_o
//   out_valid_o  output slot holds a result
//   out_ready_i  consumer accepts the result
module gray_conv_arbiter #(
  parameter int N_REQ = 4,
  parameter int D_WIDTH = 8,
  localparam int ID_WIDTH = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [N_REQ*D_WIDTH-1:0] req_data_i,
  input  logic [N_REQ-1:0]         req_mode_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  output logic [N_REQ-1:0]         req_ready_o,
  output logic [D_WIDTH-1:0]       out_data_o,
  output logic                     out_mode_o,
  output logic [ID_WIDTH-1:0]      out_id_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i
);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  slot_state_t         state_q;
  slot_state_t         state_d;
  logic [ID_WIDTH-1:0] last_grant_q;
  logic [ID_WIDTH-1:0] grant_idx;
  logic                grant_found;
  logic                slot_free;
  logic                accept;
  logic [D_WIDTH-1:0]  sel_data;
  logic                sel_mode;
  logic [D_WIDTH-1:0]  conv_data;
  logic [D_WIDTH-1:0]  data_q;
  logic                mode_q;
  logic [ID_WIDTH-1:0] id_q;

  assign out_valid_o = (state_q == SLOT_FULL);
  assign out_data_o  = data_q;
  assign out_mode_o  = mode_q;
  assign out_id_o    = id_q;

  // The slot can take a new result when empty or when it drains this cycle.
  assign slot_free = !out_valid_o || out_ready_i;
  assign accept    = slot_free && grant_found;

  // Search starts one past the last winner; the wrap is done by subtraction so
  // non-power-of-2 requester counts never produce an out-of-range index.
  always_comb begin
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = int'(last_grant_q) + off;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = ID_WIDTH'(cand);
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (accept) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  assign sel_data = req_data_i[int'(grant_idx)*D_WIDTH +: D_WIDTH];
  assign sel_mode = req_mode_i[grant_idx];

  // gray2bin is a running XOR from the MSB down.
  always_comb begin
    conv_data = '0;
    if (!sel_mode) begin
      conv_data = sel_data ^ (sel_data >> 1);
    end else begin
      conv_data[D_WIDTH-1] = sel_data[D_WIDTH-1];
      for (int k = D_WIDTH - 2; k >= 0; k--) begin
        conv_data[k] = conv_data[k+1] ^ sel_data[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = SLOT_FULL;
    end else if (out_ready_i) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= SLOT_EMPTY;
      data_q       <= '0;
      mode_q       <= 1'b0;
      id_q         <= '0;
      last_grant_q <= ID_WIDTH'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q       <= conv_data;
        mode_q       <= sel_mode;
        id_q         <= grant_idx;
        last_grant_q <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb/tb_gray_conv_arbiter.sv - self-checking bench for gray_conv_arbiter (N_REQ=4 and N_REQ=3 instances)
module tb_gray_conv_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Instance 0: N_REQ=4
  logic [31:0] data4 = '0;
  logic [3:0]  mode4 = '0;
  logic [3:0]  valid4 = '0;
  logic [3:0]  ready4;
  logic [7:0]  odata4;
  logic        omode4;
  logic [1:0]  oid4;
  logic        ov4;
  logic        ordy4 = 1'b1;

  // Instance 1: N_REQ=3
  logic [23:0] data3 = '0;
  logic [2:0]  mode3 = '0;
  logic [2:0]  valid3 = '0;
  logic [2:0]  ready3;
  logic [7:0]  odata3;
  logic        omode3;
  logic [1:0]  oid3;
  logic        ov3;
  logic        ordy3 = 1'b1;

  gray_conv_arbiter #(.N_REQ(4), .D_WIDTH(8)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_data_i(data4), .req_mode_i(mode4), .req_valid_i(valid4), .req_ready_o(ready4),
    .out_data_o(odata4), .out_mode_o(omode4), .out_id_o(oid4), .out_valid_o(ov4),
    .out_ready_i(ordy4)
  );

  gray_conv_arbiter #(.N_REQ(3), .D_WIDTH(8)) dut3 (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_data_i(data3), .req_mode_i(mode3), .req_valid_i(valid3), .req_ready_o(ready3),
    .out_data_o(odata3), .out_mode_o(omode3), .out_id_o(oid3), .out_valid_o(ov3),
    .out_ready_i(ordy3)
  );

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] b2g(input logic [7:0] x);
    return x ^ (x >> 1);
  endfunction

  // Binary is the XOR of every right shift of the Gray word.
  function automatic logic [7:0] g2b(input logic [7:0] x);
    logic [7:0] r;
    r = '0;
    for (int s = 0; s < 8; s++) r = r ^ (x >> s);
    return r;
  endfunction

  function automatic int pick(input int n, input int last, input logic [3:0] v);
    for (int d = 1; d <= n; d++) begin
      if (v[(last + d) % n]) return (last + d) % n;
    end
    return -1;
  endfunction

  function automatic int nreq(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  logic [3:0]  vin  [2];
  logic [31:0] din  [2];
  logic [3:0]  min  [2];
  logic        rin  [2];
  logic        mfree[2];
  int          mg   [2];
  logic [3:0]  eready[2];

  logic        mv   [2];
  logic [7:0]  md   [2];
  logic        mm   [2];
  int          mid  [2];
  int          mlast[2];

  always_comb begin
    vin[0] = valid4;  vin[1] = {1'b0, valid3};
    din[0] = data4;   din[1] = {8'h00, data3};
    min[0] = mode4;   min[1] = {1'b0, mode3};
    rin[0] = ordy4;   rin[1] = ordy3;
    for (int k = 0; k < 2; k++) begin
      mfree[k]  = !mv[k] || rin[k];
      mg[k]     = mfree[k] ? pick(nreq(k), mlast[k], vin[k]) : -1;
      eready[k] = (mg[k] >= 0) ? 4'(1 << mg[k]) : 4'h0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mv[k] <= 1'b0; md[k] <= '0; mm[k] <= 1'b0; mid[k] <= 0;
        mlast[k] <= nreq(k) - 1;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (mg[k] >= 0) begin
          mv[k]    <= 1'b1;
          md[k]    <= min[k][mg[k]] ? g2b(din[k][mg[k]*8 +: 8]) : b2g(din[k][mg[k]*8 +: 8]);
          mm[k]    <= min[k][mg[k]];
          mid[k]   <= mg[k];
          mlast[k] <= mg[k];
        end else if (rin[k]) begin
          mv[k] <= 1'b0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("n4_ready", {28'h0, ready4}, {28'h0, eready[0]});
      check("n4_valid", {31'h0, ov4}, {31'h0, mv[0]});
      check("n4_data", {24'h0, odata4}, {24'h0, md[0]});
      check("n4_mode", {31'h0, omode4}, {31'h0, mm[0]});
      check("n4_id", {30'h0, oid4}, 32'(mid[0]));
      check("n4_onehot0", {31'h0, $onehot0(ready4)}, 32'h1);
      check("n3_ready", {29'h0, ready3}, {28'h0, eready[1]});
      check("n3_valid", {31'h0, ov3}, {31'h0, mv[1]});
      check("n3_data", {24'h0, odata3}, {24'h0, md[1]});
      check("n3_mode", {31'h0, omode3}, {31'h0, mm[1]});
      check("n3_id", {30'h0, oid3}, 32'(mid[1]));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic expect4(input string nm, input logic [7:0] d, input logic m, input logic [1:0] id);
    check({nm, "_valid"}, {31'h0, ov4}, 32'h1);
    check({nm, "_data"}, {24'h0, odata4}, {24'h0, d});
    check({nm, "_mode"}, {31'h0, omode4}, {31'h0, m});
    check({nm, "_id"}, {30'h0, oid4}, {30'h0, id});
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", {31'h0, ov4}, 32'h0);
    check("rst_data", {24'h0, odata4}, 32'h0);
    check("rst_mode", {31'h0, omode4}, 32'h0);
    check("rst_id", {30'h0, oid4}, 32'h0);
    tick();
    rst_n = 1'b1;
    chk_en = 1'b1;

    // bin2gray on requester 2
    valid4 = 4'b0100; mode4 = 4'b0000; data4 = 32'h0005_0000;
    tick();
    expect4("b2g_05", 8'h07, 1'b0, 2'd2);
    data4 = 32'h00FF_0000;
    tick();
    expect4("b2g_ff", 8'h80, 1'b0, 2'd2);

    // gray2bin on requester 1
    valid4 = 4'b0010; mode4 = 4'b0010; data4 = 32'h0000_0700;
    tick();
    expect4("g2b_07", 8'h05, 1'b1, 2'd1);
    data4 = 32'h0000_8000;
    tick();
    expect4("g2b_80", 8'hFF, 1'b1, 2'd1);
    valid4 = 4'b0000;
    tick();

    // Round trip: v through bin2gray on req 0, its Gray code through gray2bin on req 1
    for (int v = 0; v < 256; v++) begin
      valid4 = 4'b0001; mode4 = 4'b0000; data4 = {24'h0, 8'(v)};
      tick();
      valid4 = 4'b0010; mode4 = 4'b0010; data4 = {16'h0, b2g(8'(v)), 8'h00};
      tick();
      check("round_trip", {24'h0, odata4}, 32'(v));
    end
    valid4 = 4'b0000;
    tick();

    // Round robin, all four valid
    do_reset();
    valid4 = 4'b1111; mode4 = 4'b0000; data4 = 32'h3020_1000;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rr4_id", {30'h0, oid4}, 32'(i % 4));
    end

    // Asynchronous reset with a result held
    rst_n = 1'b0;
    #1;
    check("async_valid", {31'h0, ov4}, 32'h0);
    check("async_data", {24'h0, odata4}, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    check("post_rst_id", {30'h0, oid4}, 32'h0);

    // Stall with requesters 0 and 3
    valid4 = 4'b1001; data4 = 32'h0C00_0003;
    do_reset();
    tick();
    expect4("stall_first", 8'h02, 1'b0, 2'd0);
    ordy4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect4("stall_hold", 8'h02, 1'b0, 2'd0);
      check("stall_ready", {28'h0, ready4}, 32'h0);
    end
    ordy4 = 1'b1;
    tick();
    expect4("stall_rel3", 8'h0A, 1'b0, 2'd3);
    tick();
    expect4("stall_rel0", 8'h02, 1'b0, 2'd0);
    valid4 = 4'b0000;
    tick();

    // N_REQ=3 wrap and idle gap keeping priority
    valid3 = 3'b111; data3 = 24'h03_02_01;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr3_id", {30'h0, oid3}, 32'(i % 3));
    end
    valid3 = 3'b000;
    tick();
    tick();
    check("gap_valid", {31'h0, ov3}, 32'h0);
    valid3 = 3'b111;
    tick();
    check("gap_id1", {30'h0, oid3}, 32'h1);
    tick();
    check("gap_id2", {30'h0, oid3}, 32'h2);
    valid3 = 3'b000;
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/gray_conv_arbiter.md
Name: gray_conv_arbiter

Overview:
- Shares one Gray-code conversion datapath among N_REQ requesters.
- Each request carries a data word and a mode: binary-to-Gray or Gray-to-binary.
- A round-robin arbiter picks one valid requester per cycle and converts its word. The result goes into a single registered output slot tagged with the requester ID.
- Sits between multiple pointer/counter producers (FIFO pointer logic, encoders) and their consumers; replaces per-requester converter instances.

Parameters:
- N_REQ, 4, number of requesters (>=1).
- D_WIDTH, 8, data word width in bits (>=2).
- ID_WIDTH, (N_REQ>1 ? $clog2(N_REQ) : 1), width of requester ID tag (derived, not overridden).

Ports:
- clk_i  input  1  clock, all logic on rising edge.
- rst_n_i  input  1  reset, asynchronous assert, active-low.
- req_data_i  input  N_REQ*D_WIDTH  packed request words; requester i at [i*D_WIDTH +: D_WIDTH].
- req_mode_i  input  N_REQ  per-requester mode; 0 = bin2gray, 1 = gray2bin.
- req_valid_i  input  N_REQ  per-requester request valid.
- req_ready_o  output  N_REQ  per-requester accept; at most one bit high per cycle.
- out_data_o  output  D_WIDTH  converted word.
- out_mode_o  output  1  mode used for out_data_o.
- out_id_o  output  ID_WIDTH  index of the requester that produced out_data_o.
- out_valid_o  output  1  output slot holds a result.
- out_ready_i  input  1  consumer accepts result.

Behaviour:
- Reset values (async, rst_n_i low):
  - out_valid_o=0, out_data_o=0, out_mode_o=0, out_id_o=0.
  - Round-robin pointer last_grant=N_REQ-1, so requester 0 has highest priority after reset.
- State: single output slot.
  - EMPTY (out_valid_o=0).
  - FULL (out_valid_o=1).
- Slot availability: slot_free = !out_valid_o || out_ready_i. Drain and refill can happen in the same cycle.
- Arbitration (combinational):
  - When slot_free, grant the first i with req_valid_i[i]=1, searching last_grant+1, last_grant+2, ... modulo N_REQ.
  - req_ready_o[grant]=1; all other bits 0.
  - When !slot_free or no valid request: req_ready_o=0.
  - req_ready_o may depend on req_valid_i; requesters must not make valid depend on ready.
- Handshake: transfer on requester i when req_valid_i[i] && req_ready_o[i]. Once asserted, a requester holds valid and data until it is accepted.
- Conversion (combinational on the granted word x):
  - mode 0: g = x ^ (x >> 1), with zero-filled MSB.
  - mode 1: b[D_WIDTH-1] = x[D_WIDTH-1]; b[k] = b[k+1] ^ x[k] for k descending.
  - Output is exactly D_WIDTH bits; no width growth.
- Transitions on a clock edge:
  - Accept occurs: out_data_o/out_mode_o/out_id_o load the result; out_valid_o=1; last_grant=grant.
  - No accept and out_ready_i=1: out_valid_o=0. data/mode/id hold their last values.
  - No accept and out_ready_i=0: all outputs hold.
- Latency: 1 cycle from accept to out_valid_o.
- Throughput: 1 result per cycle while out_ready_i=1.
- Stall: while out_valid_o && !out_ready_i, out_data_o/out_mode_o/out_id_o remain stable and no requester is granted.
- last_grant updates only on an accept, so idle cycles do not rotate priority.
- N_REQ=1: arbitration degenerates to pass-through gating; out_id_o is constantly 0.
- Reset mid-operation: a held result is discarded; no partial output after reset release. Arbitration restarts with requester 0 as highest priority.
- Out-of-range pointer values cannot occur. For non-power-of-2 N_REQ, the wrap is explicit at N_REQ-1 -> 0.

Test Plan:
- D_WIDTH=8, requester 2 only, mode 0, data 0x05, out_ready_i=1 -> next cycle out_valid_o=1, out_data_o=0x07, out_id_o=2, out_mode_o=0. Then data 0xFF -> 0x80.
- Requester 1, mode 1, data 0x07 -> out_data_o=0x05; data 0x80 -> 0xFF. Round trip of all 256 values through mode 0 then mode 1 returns the original value.
- All 4 requesters continuously valid, out_ready_i=1 -> grants/out_id_o sequence 0,1,2,3,0,1, one per cycle. req_ready_o is one-hot each cycle.
- Requesters 0 and 3 valid, out_ready_i low for 3 cycles after the first result -> out_* stable for 3 cycles, req_ready_o=0. On release, requester 3 is served next, then 0.
- Assert rst_n_i low mid-stream with out_valid_o=1 -> out_valid_o=0 and out_data_o=0 immediately (async). After release with all requesters valid, the first grant is requester 0.
- N_REQ=3, all valid -> out_id_o sequence 0,1,2,0 (wrap at 2). Idle gaps of 2 cycles between bursts -> priority unchanged across the gap.
